adc_frame_unpacker: RTL and testbench

//  Splits a packed ADC word (N_CH signed samples) into per-channel OUT_W samples.

---
 rtl/adc_pkg.sv | 36 +++
 rtl/adc_frame_unpacker_if.sv | 17 +
 rtl/adc_ch_conditioner.sv | 63 ++++++
 rtl/adc_frame_unpacker.sv | 91 +++++++++
 tb/tb_adc_frame_unpacker.sv | 246 ++++++++++++++++++++++++
 5 files changed

// File: rtl/adc_pkg.sv
// Shared defaults, clamp helper and pack/unpack index macro for the ADC frame unpacker.
`define ADC_IDX(k, w) ((k) * (w))

package adc_pkg;

   localparam int unsigned DEF_N_CH         = 2;
   localparam int unsigned DEF_IN_W         = 16;
   localparam int unsigned DEF_OUT_W        = 16;
   localparam int unsigned DEF_MAX_SHIFT    = 4;
   localparam int unsigned DEF_MAX_DEC_LOG2 = 8;

   typedef struct packed {
      logic               ovf;
      logic signed [31:0] val;
   } clamp_t;

   // Clamp a full-width signed value into a w-bit signed range, flagging overflow.
   function automatic clamp_t sat_clamp(input logic signed [31:0] v, input int unsigned w);
      clamp_t             r;
      logic signed [31:0] hi;
      logic signed [31:0] lo;
      hi    = (32'sd1 <<< (w - 1)) - 32'sd1;
      lo    = -(32'sd1 <<< (w - 1));
      r.ovf = 1'b0;
      r.val = v;
      if (v > hi) begin
         r.ovf = 1'b1;
         r.val = hi;
      end else if (v < lo) begin
         r.ovf = 1'b1;
         r.val = lo;
      end
      return r;
   endfunction

endpackage

// File: rtl/adc_frame_unpacker_if.sv
// Sample bus into and out of the ADC frame unpacker.
interface adc_frame_unpacker_if
   import adc_pkg::*;
#(
   parameter int unsigned N_CH  = DEF_N_CH,
   parameter int unsigned IN_W  = DEF_IN_W,
   parameter int unsigned OUT_W = DEF_OUT_W
);
   logic [N_CH*IN_W-1:0]  bundle_i;
   logic                  valid_i;
   logic [N_CH*OUT_W-1:0] data_o;
   logic                  valid_o;
   logic [N_CH-1:0]       sat_o;

   modport master (output bundle_i, valid_i, input  data_o, valid_o, sat_o);
   modport slave  (input  bundle_i, valid_i, output data_o, valid_o, sat_o);
endinterface

// File: rtl/adc_ch_conditioner.sv
// One channel: gain shift with saturation, sticky sat flag, boxcar accumulator and average.
module adc_ch_conditioner
   import adc_pkg::*;
#(
   parameter int unsigned IN_W         = DEF_IN_W,
   parameter int unsigned OUT_W        = DEF_OUT_W,
   parameter int unsigned MAX_SHIFT    = DEF_MAX_SHIFT,
   parameter int unsigned MAX_DEC_LOG2 = DEF_MAX_DEC_LOG2,
   parameter int unsigned SH_W         = $clog2(MAX_SHIFT + 1),
   parameter int unsigned DEC_W        = 4
) (
   input  logic             clk_i,
   input  logic             rstn_i,
   input  logic [IN_W-1:0]  sample_i,
   input  logic             valid_i,
   input  logic [SH_W-1:0]  shift_i,
   input  logic             clr_sat_i,
   input  logic             s1_valid_i,
   input  logic             abort_i,
   input  logic             load_i,
   input  logic             emit_i,
   input  logic [DEC_W-1:0] dec_i,
   output logic [OUT_W-1:0] data_o,
   output logic             sat_o
);
   localparam int unsigned ACC_W = OUT_W + MAX_DEC_LOG2;

   logic [SH_W-1:0]         sh;
   logic signed [31:0]      wide;
   clamp_t                  cl;
   logic [OUT_W-1:0]        s1_q;
   logic signed [ACC_W-1:0] acc_q;
   logic signed [ACC_W-1:0] acc_next;
   logic signed [ACC_W-1:0] avg;
   logic                    unused_bits;

   // The first sample of a window replaces the accumulator so windows run back to back.
   always_comb begin
      sh       = (shift_i > SH_W'(MAX_SHIFT)) ? SH_W'(MAX_SHIFT) : shift_i;
      wide     = 32'(signed'(sample_i)) <<< sh;
      cl       = sat_clamp(wide, OUT_W);
      acc_next = load_i ? ACC_W'(signed'(s1_q)) : acc_q + ACC_W'(signed'(s1_q));
      avg      = acc_next >>> dec_i;
   end

   assign unused_bits = ^{cl.val[31:OUT_W], avg[ACC_W-1:OUT_W]};

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         s1_q   <= '0;
         acc_q  <= '0;
         data_o <= '0;
         sat_o  <= 1'b0;
      end else begin
         if (valid_i) s1_q <= cl.val[OUT_W-1:0];
         if (valid_i && cl.ovf) sat_o <= 1'b1;
         else if (clr_sat_i)    sat_o <= 1'b0;
         if (abort_i)           acc_q <= '0;
         else if (s1_valid_i)   acc_q <= acc_next;
         if (emit_i) data_o <= avg[OUT_W-1:0];
      end
   end
endmodule

// File: rtl/adc_frame_unpacker.sv
// Splits a packed ADC word into per-channel samples with gain, saturation and decimation.
module adc_frame_unpacker
   import adc_pkg::*;
#(
   parameter int unsigned N_CH         = DEF_N_CH,
   parameter int unsigned IN_W         = DEF_IN_W,
   parameter int unsigned OUT_W        = DEF_OUT_W,
   parameter int unsigned MAX_SHIFT    = DEF_MAX_SHIFT,
   parameter int unsigned MAX_DEC_LOG2 = DEF_MAX_DEC_LOG2,
   parameter int unsigned SH_W         = $clog2(MAX_SHIFT + 1)
) (
   input  logic            clk_i,
   input  logic            rstn_i,
   adc_frame_unpacker_if.slave bus,
   input  logic [SH_W-1:0] shift_i,
   input  logic [3:0]      dec_log2_i,
   input  logic            clr_sat_i
);
   localparam int unsigned CNT_W = (MAX_DEC_LOG2 > 0) ? MAX_DEC_LOG2 : 1;

   logic [3:0]       dec_clamp;
   logic [3:0]       dec_cur;
   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_last;
   logic             s1_valid_q;
   logic             valid_q;
   logic             abort;
   logic             load;
   logic             emit;
   logic [OUT_W-1:0] ch_data [N_CH];
   logic [N_CH-1:0]  ch_sat;

   // A changed exponent aborts the open window and drops stage-1 data of that cycle.
   always_comb begin
      dec_clamp = (dec_log2_i > 4'(MAX_DEC_LOG2)) ? 4'(MAX_DEC_LOG2) : dec_log2_i;
      abort     = dec_clamp != dec_cur;
      cnt_last  = CNT_W'((32'd1 << dec_cur) - 32'd1);
      load      = cnt_q == '0;
      emit      = s1_valid_q && !abort && (cnt_q == cnt_last);
   end

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         dec_cur    <= '0;
         cnt_q      <= '0;
         s1_valid_q <= 1'b0;
         valid_q    <= 1'b0;
      end else begin
         dec_cur    <= dec_clamp;
         s1_valid_q <= bus.valid_i;
         valid_q    <= emit;
         if (abort)           cnt_q <= '0;
         else if (s1_valid_q) cnt_q <= emit ? '0 : cnt_q + CNT_W'(1);
      end
   end

   for (genvar k = 0; k < N_CH; k++) begin : g_ch
      adc_ch_conditioner #(
         .IN_W        (IN_W),
         .OUT_W       (OUT_W),
         .MAX_SHIFT   (MAX_SHIFT),
         .MAX_DEC_LOG2(MAX_DEC_LOG2),
         .SH_W        (SH_W),
         .DEC_W       (4)
      ) u_ch (
         .clk_i     (clk_i),
         .rstn_i    (rstn_i),
         .sample_i  (bus.bundle_i[`ADC_IDX(k, IN_W) +: IN_W]),
         .valid_i   (bus.valid_i),
         .shift_i   (shift_i),
         .clr_sat_i (clr_sat_i),
         .s1_valid_i(s1_valid_q),
         .abort_i   (abort),
         .load_i    (load),
         .emit_i    (emit),
         .dec_i     (dec_cur),
         .data_o    (ch_data[k]),
         .sat_o     (ch_sat[k])
      );
   end

   always_comb begin
      bus.data_o = '0;
      for (int unsigned k = 0; k < N_CH; k++) begin
         bus.data_o[`ADC_IDX(k, OUT_W) +: OUT_W] = ch_data[k];
      end
   end

   assign bus.valid_o = valid_q;
   assign bus.sat_o   = ch_sat;
endmodule

// File: tb/tb_adc_frame_unpacker.sv
// Directed bench for adc_frame_unpacker with a window-average reference model.
module tb_adc_frame_unpacker;
   localparam int N_CH  = 2;
   localparam int IN_W  = 16;
   localparam int OUT_W = 16;

   logic       clk    = 1'b0;
   logic       rstn   = 1'b1;
   logic [2:0] shift  = '0;
   logic [3:0] dec    = '0;
   logic       clr    = 1'b0;
   logic       mon_en = 1'b0;
   int checks = 0;
   int errors = 0;
   int vcount = 0;
   int v0;

   adc_frame_unpacker_if #(.N_CH(N_CH), .IN_W(IN_W), .OUT_W(OUT_W)) bus ();

   adc_frame_unpacker #(
      .N_CH(N_CH), .IN_W(IN_W), .OUT_W(OUT_W), .MAX_SHIFT(4), .MAX_DEC_LOG2(8)
   ) dut (
      .clk_i     (clk),
      .rstn_i    (rstn),
      .bus       (bus),
      .shift_i   (shift),
      .dec_log2_i(dec),
      .clr_sat_i (clr)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic signed [63:0] got, input logic signed [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0d expected=%0d", name, got, exp);
      end
   endtask

   // Reference model: outputs after each edge, from the averaging rules directly.
   int         m_data [N_CH];
   logic       m_valid;
   logic [N_CH-1:0] m_sat;
   logic       m_s1v;
   int         m_s1 [N_CH];
   int         m_dec;
   longint     m_sum [N_CH];
   int         m_n;

   function automatic int floordiv(input longint s, input int d);
      if (s >= 0) return int'(s / d);
      return -int'((-s + d - 1) / d);
   endfunction

   task automatic model_step();
      int dd, sh, x, y;
      logic ovf;
      logic signed [15:0] t;
      if (!rstn) begin
         m_valid = 1'b0;
         m_sat   = '0;
         m_s1v   = 1'b0;
         m_dec   = 0;
         m_n     = 0;
         for (int k = 0; k < N_CH; k++) begin
            m_data[k] = 0;
            m_s1[k]   = 0;
            m_sum[k]  = 0;
         end
         return;
      end
      dd      = (dec > 4'd8) ? 8 : int'(dec);
      m_valid = 1'b0;
      if (dd != m_dec) begin
         m_dec = dd;
         m_n   = 0;
         for (int k = 0; k < N_CH; k++) m_sum[k] = 0;
      end else if (m_s1v) begin
         m_n++;
         for (int k = 0; k < N_CH; k++) m_sum[k] += m_s1[k];
         if (m_n == (1 << m_dec)) begin
            for (int k = 0; k < N_CH; k++) begin
               m_data[k] = floordiv(m_sum[k], 1 << m_dec);
               m_sum[k]  = 0;
            end
            m_valid = 1'b1;
            m_n     = 0;
         end
      end
      m_s1v = bus.valid_i;
      sh    = (shift > 3'd4) ? 4 : int'(shift);
      for (int k = 0; k < N_CH; k++) begin
         t   = bus.bundle_i[k*IN_W +: IN_W];
         x   = int'(t);
         y   = x * (1 << sh);
         ovf = 1'b0;
         if (y > 32767)       begin y = 32767;  ovf = 1'b1; end
         else if (y < -32768) begin y = -32768; ovf = 1'b1; end
         if (bus.valid_i) m_s1[k] = y;
         if (bus.valid_i && ovf) m_sat[k] = 1'b1;
         else if (clr)           m_sat[k] = 1'b0;
      end
   endtask

   initial forever begin
      @(posedge clk or negedge rstn);
      model_step();
   end

   initial forever begin
      @(negedge clk);
      if (mon_en) begin
         chk("mon_valid_o", bus.valid_o, m_valid);
         chk("mon_sat_o", bus.sat_o, m_sat);
         for (int k = 0; k < N_CH; k++)
            chk($sformatf("mon_data_ch%0d", k), $signed(bus.data_o[k*OUT_W +: OUT_W]), m_data[k]);
         if (bus.valid_o === 1'b1) vcount++;
      end
   end

   task automatic drive(input logic [15:0] c1, input logic [15:0] c0, input logic v);
      bus.bundle_i = {c1, c0};
      bus.valid_i  = v;
      @(posedge clk);
      #1;
   endtask

   initial begin
      bus.bundle_i = '0;
      bus.valid_i  = 1'b0;
      #1 rstn = 1'b0;
      @(posedge clk); #1;
      mon_en = 1'b1;
      chk("rst_data", bus.data_o, 0);
      chk("rst_valid", bus.valid_o, 0);
      chk("rst_sat", bus.sat_o, 0);
      @(posedge clk); #1;
      rstn = 1'b1;
      drive(0, 0, 0);

      // Gain 2, pass-through, latency 2
      shift = 3'd2;
      drive(16'h0FFF, 16'hF000, 1);
      drive(0, 0, 0);
      chk("t1_valid", bus.valid_o, 1);
      chk("t1_data", bus.data_o, 32'h3FFC_C000);
      chk("t1_sat", bus.sat_o, 0);
      drive(0, 0, 0);

      // Saturation, sticky flag, set beats clear
      shift = 3'd4;
      drive(0, 16'h1000, 1);
      chk("t2_sat_set", bus.sat_o, 2'b01);
      drive(0, 0, 0);
      chk("t2_pos_clamp", bus.data_o[15:0], 16'h7FFF);
      clr = 1'b1;
      drive(0, 16'hF000, 1);
      clr = 1'b0;
      chk("t2_set_wins", bus.sat_o, 2'b01);
      drive(0, 0, 0);
      chk("t2_neg_clamp", bus.data_o[15:0], 16'h8000);
      clr = 1'b1;
      drive(0, 0, 0);
      clr = 1'b0;
      chk("t2_sat_clr", bus.sat_o, 2'b00);

      // Decimate by 4, positive and floored negative averages
      shift = 3'd0;
      dec   = 4'd2;
      drive(0, 0, 0);
      v0 = vcount;
      drive(16'd100, 16'd1, 1);
      drive(16'd200, 16'd2, 1);
      drive(16'd300, 16'd3, 1);
      drive(16'd400, 16'd6, 1);
      drive(0, 0, 0);
      chk("t3_valid", bus.valid_o, 1);
      chk("t3_avg", bus.data_o, {16'd250, 16'd3});
      drive(0, 0, 0);
      chk("t3_one_strobe", vcount - v0, 1);
      drive(16'h0000, 16'hFFFF, 1);
      drive(16'h0000, 16'hFFFF, 1);
      drive(16'h0000, 16'hFFFF, 1);
      drive(16'hFFFF, 16'hFFFE, 1);
      drive(0, 0, 0);
      chk("t3_floor", bus.data_o, 32'hFFFF_FFFE);

      // Exponent change aborts a partial window
      dec = 4'd3;
      drive(0, 0, 0);
      v0 = vcount;
      repeat (5) drive(16'd3, 16'd7, 1);
      dec = 4'd1;
      drive(0, 0, 0);
      drive(0, 0, 0);
      chk("t4_no_valid", vcount - v0, 0);
      drive(16'd3, 16'd10, 1);
      drive(16'd4, 16'd20, 1);
      drive(0, 0, 0);
      chk("t4_avg", bus.data_o, {16'd3, 16'd15});

      // Gaps between accepted samples
      drive(16'd1, 16'd100, 1);
      drive(0, 0, 0);
      drive(16'd2, 16'hFFCE, 1);
      drive(0, 0, 0);
      chk("t5_valid", bus.valid_o, 1);
      chk("t5_avg", bus.data_o, {16'd1, 16'd25});
      drive(0, 16'd7, 1);
      drive(0, 0, 0);
      drive(0, 16'd8, 1);
      drive(0, 0, 0);
      chk("t5_avg2", bus.data_o[15:0], 16'd7);

      // Asynchronous reset mid-window, then a fresh 16-sample window
      shift = 3'd4;
      dec   = 4'd4;
      drive(0, 0, 0);
      repeat (7) drive(16'h4000, 16'd1000, 1);
      chk("t6_sat_pre", bus.sat_o, 2'b10);
      rstn = 1'b0;
      #1;
      chk("t6_rst_data", bus.data_o, 0);
      chk("t6_rst_valid", bus.valid_o, 0);
      chk("t6_rst_sat", bus.sat_o, 0);
      @(posedge clk); #1;
      rstn  = 1'b1;
      shift = 3'd0;
      drive(0, 0, 0);
      v0 = vcount;
      for (int i = 1; i <= 15; i++) drive(16'(-i), 16'(i), 1);
      drive(0, 0, 0);
      drive(0, 0, 0);
      chk("t6_partial", vcount - v0, 0);
      drive(16'(-16), 16'd16, 1);
      drive(0, 0, 0);
      chk("t6_valid", bus.valid_o, 1);
      chk("t6_avg", bus.data_o, 32'hFFF7_0008);
      drive(0, 0, 0);
      drive(0, 0, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
